// File: rtl/pipe_ctrl.sv
// EX-stage pipeline sequencer: redirect, stall and flush control for pc_reg/if_id/id_ex.
// Optional perf counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_hold_i,
  input  logic        fetch_wait_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_FLUSH = 2'd1, S_STALL = 2'd2, S_ERROR = 2'd3} state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [9:0] WD_LIMIT   = 10'(HOLD_TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [9:0]  wd_q, wd_d;

  logic        jump_c, stall_pc_c, stall_if_id_c, stall_id_ex_c, flush_if_id_c, flush_id_ex_c;
  logic [31:0] addr_c;

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    wd_d          = wd_q;
    jump_c        = 1'b0;
    addr_c        = 32'h0;
    stall_pc_c    = 1'b0;
    stall_if_id_c = 1'b0;
    stall_id_ex_c = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    case (state_q)
      S_RUN, S_FLUSH, S_STALL: begin
        if (ex_hold_i) begin
          // An unfinished EX result outranks any jump; remaining flush count is dropped.
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
          flush_if_id_c = (state_q == S_FLUSH);
          fcnt_d        = 4'd0;
          if (state_q == S_STALL) begin
            wd_d    = wd_q + 10'd1;
            state_d = (wd_q + 10'd1 == WD_LIMIT) ? S_ERROR : S_STALL;
          end else begin
            wd_d    = 10'd1;
            state_d = S_STALL;
          end
        end else if (jump_en_i) begin
          jump_c        = 1'b1;
          addr_c        = jump_addr_i;
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          fcnt_d        = FLUSH_LOAD;
          wd_d          = 10'd0;
          state_d       = (FLUSH_LOAD != 4'd0) ? S_FLUSH : S_RUN;
        end else begin
          wd_d       = 10'd0;
          stall_pc_c = fetch_wait_i;
          if (state_q == S_FLUSH) begin
            // Flush window only advances on cycles that deliver a fetch response.
            flush_if_id_c = 1'b1;
            if (!fetch_wait_i) begin
              fcnt_d = fcnt_q - 4'd1;
              if (fcnt_q == 4'd1) state_d = S_RUN;
            end
          end else begin
            flush_if_id_c = fetch_wait_i;
            state_d       = S_RUN;
          end
        end
      end
      default: begin
        stall_pc_c    = 1'b1;
        stall_if_id_c = 1'b1;
        stall_id_ex_c = 1'b1;
        flush_id_ex_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      fcnt_q  <= 4'd0;
      wd_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wd_q    <= wd_d;
    end
  end

  assign jump_en_o     = ~rst & jump_c;
  assign jump_addr_o   = rst ? 32'h0 : addr_c;
  assign stall_pc_o    = ~rst & stall_pc_c;
  assign stall_if_id_o = ~rst & stall_if_id_c;
  assign stall_id_ex_o = ~rst & stall_id_ex_c;
  assign flush_if_id_o = ~rst & flush_if_id_c;
  assign flush_id_ex_o = ~rst & flush_id_ex_c;
  assign state_o       = rst ? 2'd0 : state_q;
  assign err_o         = ~rst & (state_q == S_ERROR);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_pc_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (jump_c && (flush_cnt_q != 32'hFFFF_FFFF))     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = rst ? 32'h0 : stall_cnt_q;
  assign flush_cnt_o = rst ? 32'h0 : flush_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
  assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  localparam int FC = 2;
  localparam int HT = 64;

  logic        clk = 1'b0;
  logic        rst, jump_en_i, ex_hold_i, fetch_wait_i;
  logic [31:0] jump_addr_i;
  logic        jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o, err_o;
  logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: abstract quantities rather than a state register.
  bit          m_err;
  int          m_flush_left;
  int          m_hold_len;
  logic [31:0] m_scnt, m_fcnt;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .fetch_wait_i(fetch_wait_i), .jump_en_o(jump_en_o),
    .jump_addr_o(jump_addr_o), .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o), .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .state_o(state_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Per-cycle compare against the model, then advance the model past the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_je, e_spc, e_sif, e_sid, e_fif, e_fid;
      logic [31:0] e_addr;
      logic [1:0]  e_st;
      e_je = 0; e_spc = 0; e_sif = 0; e_sid = 0; e_fif = 0; e_fid = 0;
      e_addr = 32'h0; e_st = 2'd0;
      if (!rst) begin
        e_st = m_err ? 2'd3 : (m_hold_len > 0) ? 2'd2 : (m_flush_left > 0) ? 2'd1 : 2'd0;
        if (m_err) begin
          e_spc = 1; e_sif = 1; e_sid = 1; e_fid = 1;
        end else if (ex_hold_i) begin
          e_spc = 1; e_sif = 1; e_sid = 1; e_fif = (m_flush_left > 0);
        end else if (jump_en_i) begin
          e_je = 1; e_addr = jump_addr_i; e_fif = 1; e_fid = 1;
        end else begin
          e_spc = fetch_wait_i; e_fif = fetch_wait_i || (m_flush_left > 0);
        end
      end
      chk("ctrl", {57'd0, jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o, err_o},
                  {57'd0, e_je, e_spc, e_sif, e_sid, e_fif, e_fid, (!rst && m_err)});
      chk("addr", {32'd0, jump_addr_o}, {32'd0, e_addr});
      chk("state", {62'd0, state_o}, {62'd0, e_st});
`ifdef PIPE_CTRL_PERF_EN
      chk("counters", {stall_cnt_o, flush_cnt_o}, rst ? 64'd0 : {m_scnt, m_fcnt});
`else
      chk("counters", {stall_cnt_o, flush_cnt_o}, 64'd0);
`endif
      if (rst) begin
        m_err = 0; m_flush_left = 0; m_hold_len = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
        m_scnt = sat_inc(m_scnt, e_spc);
        m_fcnt = sat_inc(m_fcnt, e_je);
        if (!m_err) begin
          if (ex_hold_i) begin
            m_hold_len++;
            m_flush_left = 0;
            if (m_hold_len >= HT) m_err = 1;
          end else begin
            m_hold_len = 0;
            if (jump_en_i) m_flush_left = FC - 1;
            else if (m_flush_left > 0 && !fetch_wait_i) m_flush_left--;
          end
        end
      end
    end
  end

  task automatic set_in(input logic r, input logic j, input logic [31:0] a, input logic h, input logic f);
    @(posedge clk);
    #1;
    rst = r; jump_en_i = j; jump_addr_i = a; ex_hold_i = h; fetch_wait_i = f;
    #2;
  endtask

  task automatic idle();
    set_in(0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    int hold_pct;
    rst = 1; jump_en_i = 0; jump_addr_i = 0; ex_hold_i = 0; fetch_wait_i = 0;

    // Reset with competing requests asserted.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 32'hDEAD_BEEF, 1, 0);
      chk_en = 1'b1;
      chk("rst_outs", {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o, err_o, state_o, jump_addr_o}, 0);
    end
    idle();
    chk("rst_release_state", state_o, 2'd0);

    // Single redirect.
    set_in(0, 1, 32'h100, 0, 0);
    chk("jump_strobe", {jump_en_o, flush_if_id_o, flush_id_ex_o}, 3'b111);
    chk("jump_addr", jump_addr_o, 32'h100);
    idle();
    chk("flush2", {jump_en_o, flush_if_id_o, state_o}, {1'b0, 1'b1, 2'd1});
    idle();
    chk("flush_done", {flush_if_id_o, state_o}, {1'b0, 2'd0});

    // Fetch wait freezes the flush window.
    set_in(0, 1, 32'h140, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 32'h0, 0, 1);
      chk("flush_frozen", {flush_if_id_o, stall_pc_o, state_o}, {1'b1, 1'b1, 2'd1});
    end
    idle();
    chk("flush_resume", {flush_if_id_o, state_o}, {1'b1, 2'd1});
    idle();
    chk("flush_exit", state_o, 2'd0);

    // Hold suppresses a concurrent jump.
    for (int i = 0; i < 5; i++) begin
      set_in(0, (i == 4), 32'h200, 1, 0);
      chk("hold_stalls", {stall_pc_o, stall_if_id_o, stall_id_ex_o, jump_en_o, flush_id_ex_o}, 5'b11100);
    end
    idle();
    chk("hold_release", {stall_pc_o, stall_if_id_o, stall_id_ex_o, jump_en_o, state_o}, {4'b0000, 2'd2});
    idle();
    chk("hold_after", {jump_en_o, state_o}, {1'b0, 2'd0});

    // Watchdog boundary: still STALL on the last allowed cycle, ERROR afterwards.
    for (int i = 0; i < HT; i++) begin
      set_in(0, 0, 32'h0, 1, 0);
      if (i == HT - 1) chk("wd_edge_state", state_o, 2'd2);
    end
    set_in(0, 1, 32'h300, 0, 0);
    chk("err_state", {state_o, err_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_id_ex_o, jump_en_o}, {2'd3, 6'b111110});
    set_in(1, 0, 32'h0, 0, 0);
    chk("err_rst", {state_o, err_o}, 3'b000);
    idle();
    chk("err_recover", {state_o, err_o}, 3'b000);

`ifdef PIPE_CTRL_PERF_EN
    set_in(1, 0, 32'h0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 32'h400 + 32'(k * 4), 0, 0);
      idle();
      idle();
    end
    for (int i = 0; i < 5; i++) set_in(0, 0, 32'h0, 1, 0);
    idle();
    idle();
    chk("perf_flush", flush_cnt_o, 32'd3);
    chk("perf_stall", stall_cnt_o, 32'd5);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_scnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) set_in(0, 0, 32'h0, 1, 0);
    idle();
    idle();
    chk("perf_sat", stall_cnt_o, 32'hFFFF_FFFF);
`endif

    // Randomized traffic with alternating light and heavy hold phases.
    hold_pct = 20;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) hold_pct = ($urandom_range(0, 2) == 0) ? 97 : 20;
      set_in(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 25),
             $urandom,
             ($urandom_range(0, 99) < hold_pct),
             ($urandom_range(0, 99) < 25));
    end
    idle();
    @(negedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
